pixel_cmd_decoder: RTL and testbench

Converts the byte stream delivered by the SPI peripheral into pixel writes for the display's write port (write_en, write_x, write_y, write_color). It parses fixed 4-byte command packets and issues single-pixel writes, row fills and full-screen fills at one write per clock. It holds one pending packet while a fill is in progress.

---
 rtl/pixel_pkg.sv | 33 +++
 rtl/pixel_packet_assembler.sv | 57 +++++
 rtl/pixel_cmd_decoder.sv | 177 +++++++++++++++++
 tb/tb_pixel_cmd_decoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pkg
// Purpose  : Shared widths, opcode/state encodings and packet layout for the
//            SPI-to-pixel command decoder.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    localparam int COORD_W = 6;
    localparam int COLOR_W = 12;

    typedef enum logic [1:0] {
        OP_PIXEL = 2'b00,
        OP_FILL  = 2'b01,
        OP_ROW   = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_t;

    typedef struct packed {
        opcode_t              op;
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
        logic [COLOR_W-1:0]   color;
    } packet_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module   : pixel_packet_assembler
// Purpose  : Collects 4-byte command packets from the SPI byte strobe, with
//            frame_sync realignment; the packet is presented with byte 3.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_packet_assembler
    import pixel_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    input  logic          i_frame_sync,
    output logic          o_pkt_valid,
    output packet_t       o_pkt
);

    logic [1:0]          r_idx;
    logic [7:0]          r_byte0;
    logic [COORD_W-1:0]  r_y;
    logic [7:0]          r_byte2;
    logic [1:0]          w_idx;

    // A byte arriving together with frame_sync is treated as byte 0.
    assign w_idx = i_frame_sync ? 2'd0 : r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_byte0 <= 8'd0;
            r_y     <= '0;
            r_byte2 <= 8'd0;
        end else if (i_byte_valid) begin
            r_idx <= w_idx + 2'd1;
            case (w_idx)
                2'd0:    r_byte0 <= i_byte_data;
                2'd1:    r_y     <= i_byte_data[COORD_W-1:0];
                2'd2:    r_byte2 <= i_byte_data;
                default: ;
            endcase
        end else if (i_frame_sync) begin
            r_idx <= 2'd0;
        end
    end

    // Byte 3 is forwarded directly so the write can be registered in the
    // same edge that receives it.
    assign o_pkt_valid = i_byte_valid && (w_idx == 2'd3);
    assign o_pkt.op    = opcode_t'(r_byte0[7:6]);
    assign o_pkt.x     = r_byte0[COORD_W-1:0];
    assign o_pkt.y     = r_y;
    assign o_pkt.color = {r_byte2, i_byte_data[7:4]};

endmodule
`default_nettype wire

// File: rtl/pixel_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pixel_cmd_decoder
// Purpose  : Turns SPI command packets into display pixel writes: single
//            pixels, row fills and full-screen fills, one write per clock.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_cmd_decoder
    import pixel_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 frame_sync,
    output logic                 write_en,
    output logic [COORD_W-1:0]   write_x,
    output logic [COORD_W-1:0]   write_y,
    output logic [COLOR_W-1:0]   write_color,
    output logic                 busy,
    output logic                 overflow
);

    localparam logic [COORD_W-1:0] c_coord_max = '1;
    localparam logic [COORD_W-1:0] c_coord_one = COORD_W'(1);

    logic                 w_pkt_valid;
    packet_t              w_pkt;

    state_t               r_state;
    logic                 r_pend_valid;
    packet_t              r_pend;
    logic                 r_run_fill;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic [COLOR_W-1:0]   r_color;

    logic                 r_write_en;
    logic [COORD_W-1:0]   r_write_x;
    logic [COORD_W-1:0]   r_write_y;
    logic [COLOR_W-1:0]   r_write_color;
    logic                 r_busy;
    logic                 r_overflow;

    logic                 w_start_valid;
    packet_t              w_start_pkt;
    logic                 w_run_last;

    pixel_packet_assembler u_assembler (
        .clk          (clk_in),
        .rst          (reset),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .i_frame_sync (frame_sync),
        .o_pkt_valid  (w_pkt_valid),
        .o_pkt        (w_pkt)
    );

    // When idle, the pending packet always has priority over a new arrival.
    always_comb begin
        w_start_valid = 1'b0;
        w_start_pkt   = w_pkt;
        if (r_state == IDLE) begin
            if (r_pend_valid) begin
                w_start_valid = 1'b1;
                w_start_pkt   = r_pend;
            end else begin
                w_start_valid = w_pkt_valid;
            end
        end
    end

    assign w_run_last = (r_x == c_coord_max) && (!r_run_fill || (r_y == c_coord_max));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pend_valid  <= 1'b0;
            r_pend        <= '0;
            r_run_fill    <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_color       <= '0;
            r_write_en    <= 1'b0;
            r_write_x     <= '0;
            r_write_y     <= '0;
            r_write_color <= '0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            r_busy     <= 1'b0;

            // Pending slot: drained and refilled in the same cycle when idle.
            if (r_state == IDLE) begin
                if (r_pend_valid) begin
                    r_pend_valid <= w_pkt_valid;
                    r_pend       <= w_pkt;
                end
            end else if (w_pkt_valid) begin
                if (!r_pend_valid) begin
                    r_pend_valid <= 1'b1;
                    r_pend       <= w_pkt;
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_start_valid) begin
                        case (w_start_pkt.op)
                            OP_PIXEL: begin
                                r_write_en    <= 1'b1;
                                r_write_x     <= w_start_pkt.x;
                                r_write_y     <= w_start_pkt.y;
                                r_write_color <= w_start_pkt.color;
                            end
                            OP_FILL: begin
                                r_write_en    <= 1'b1;
                                r_busy        <= 1'b1;
                                r_write_x     <= '0;
                                r_write_y     <= '0;
                                r_write_color <= w_start_pkt.color;
                                r_x           <= c_coord_one;
                                r_y           <= '0;
                                r_color       <= w_start_pkt.color;
                                r_run_fill    <= 1'b1;
                                r_state       <= RUN;
                            end
                            OP_ROW: begin
                                r_write_en    <= 1'b1;
                                r_busy        <= 1'b1;
                                r_write_x     <= w_start_pkt.x;
                                r_write_y     <= w_start_pkt.y;
                                r_write_color <= w_start_pkt.color;
                                // A row starting at the last column is a single write.
                                if (w_start_pkt.x != c_coord_max) begin
                                    r_x        <= w_start_pkt.x + c_coord_one;
                                    r_y        <= w_start_pkt.y;
                                    r_color    <= w_start_pkt.color;
                                    r_run_fill <= 1'b0;
                                    r_state    <= RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    r_write_en    <= 1'b1;
                    r_busy        <= 1'b1;
                    r_write_x     <= r_x;
                    r_write_y     <= r_y;
                    r_write_color <= r_color;
                    r_x           <= r_x + c_coord_one;
                    if (r_run_fill && (r_x == c_coord_max)) begin
                        r_y <= r_y + c_coord_one;
                    end
                    if (w_run_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign write_en    = r_write_en;
    assign write_x     = r_write_x;
    assign write_y     = r_write_y;
    assign write_color = r_write_color;
    assign busy        = r_busy;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pixel_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_cmd_decoder
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random packet traffic against a write-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        frame_sync = 1'b0;
    logic        write_en;
    logic [5:0]  write_x;
    logic [5:0]  write_y;
    logic [11:0] write_color;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    pixel_cmd_decoder dut (
        .clk_in      (clk),
        .reset       (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_sync  (frame_sync),
        .write_en    (write_en),
        .write_x     (write_x),
        .write_y     (write_y),
        .write_color (write_color),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int x;
        int y;
        int col;
        bit fill;
    } wr_t;

    typedef struct {
        logic [31:0] pkt;
        int          n;
        int          nbusy;
        int          fx;
        int          fy;
        int          lx;
        int          ly;
        int          col;
    } vec_t;

    // ------------------------------------------------------------------
    // Reference model: each packet expands into its list of pixel writes,
    // scheduled one per cycle; one running command plus one waiting slot.
    // ------------------------------------------------------------------
    wr_t         exp_q[$];
    wr_t         log_q[$];
    int          ecnt = 0;
    int          free_at = 0;
    int          m_idx = 0;
    logic [7:0]  m_bytes [4];
    bit          m_pend_v = 0;
    logic [31:0] m_pend = 0;
    bit          m_ovf = 0;
    bit          m_got;
    logic [31:0] m_pk;
    int          bcount = 0;

    task automatic push_wr(input int c, input int x, input int y, input int col, input bit f);
        wr_t w;
        w.cyc = c; w.x = x; w.y = y; w.col = col; w.fill = f;
        exp_q.push_back(w);
    endtask

    task automatic model_start(input logic [31:0] p, input int t);
        int n;
        int op;
        int x;
        int y;
        int col;
        n   = 0;
        op  = int'(p[31:30]);
        x   = int'(p[29:24]);
        y   = int'(p[21:16]);
        col = int'({p[15:8], p[7:4]});
        if (op == 0) begin
            push_wr(t, x, y, col, 0);
            n = 1;
        end else if (op == 1) begin
            for (int yy = 0; yy < 64; yy++)
                for (int xx = 0; xx < 64; xx++) begin
                    push_wr(t + n, xx, yy, col, 1);
                    n++;
                end
        end else if (op == 2) begin
            for (int xx = x; xx < 64; xx++) begin
                push_wr(t + n, xx, y, col, 1);
                n++;
            end
        end
        free_at = t + ((n > 0) ? n : 1);
    endtask

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (rst) begin
            m_idx = 0;
            m_pend_v = 0;
            m_ovf = 0;
            free_at = 0;
            exp_q.delete();
        end else begin
            m_got = 0;
            if (frame_sync) m_idx = 0;
            if (byte_valid) begin
                m_bytes[m_idx] = byte_data;
                if (m_idx == 3) begin
                    m_got = 1;
                    m_pk  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                end
                m_idx = (m_idx + 1) % 4;
            end
            if (ecnt >= free_at) begin
                if (m_pend_v) begin
                    model_start(m_pend, ecnt);
                    m_pend_v = m_got;
                    m_pend   = m_pk;
                end else if (m_got) begin
                    model_start(m_pk, ecnt);
                end
            end else if (m_got) begin
                if (!m_pend_v) begin
                    m_pend_v = 1;
                    m_pend   = m_pk;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    // Cycle monitor, sampled mid-cycle.
    wr_t mon_w;
    bit  mon_exp;
    always @(negedge clk) begin
        if (!rst) begin
            mon_exp = (exp_q.size() != 0) && (exp_q[0].cyc == ecnt);
            checks++;
            if (mon_exp) begin
                mon_w = exp_q.pop_front();
                if (write_en !== 1'b1 || busy !== mon_w.fill || overflow !== m_ovf ||
                    write_x !== 6'(mon_w.x) || write_y !== 6'(mon_w.y) ||
                    write_color !== 12'(mon_w.col)) begin
                    failures++;
                    $display("FAIL cycle_write @%0d: got we=%b busy=%b ovf=%b (%0d,%0d) col=%h, expected we=1 busy=%b ovf=%b (%0d,%0d) col=%h",
                             ecnt, write_en, busy, overflow, write_x, write_y, write_color,
                             mon_w.fill, m_ovf, mon_w.x, mon_w.y, 12'(mon_w.col));
                end
            end else if (write_en !== 1'b0 || busy !== 1'b0 || overflow !== m_ovf) begin
                failures++;
                $display("FAIL cycle_idle @%0d: got we=%b busy=%b ovf=%b, expected we=0 busy=0 ovf=%b",
                         ecnt, write_en, busy, overflow, m_ovf);
            end
            if (write_en === 1'b1) begin
                mon_w.cyc = ecnt; mon_w.x = int'(write_x); mon_w.y = int'(write_y);
                mon_w.col = int'(write_color); mon_w.fill = busy;
                log_q.push_back(mon_w);
            end
            if (busy === 1'b1) bcount++;
        end
    end

    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fs);
        byte_valid = 1'b1;
        byte_data  = d;
        frame_sync = fs;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] p, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(p[31-8*i -: 8], 1'b0);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic wait_drain(input int maxc);
        int i;
        for (i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0 && busy === 1'b0 && !m_pend_v) break;
            @(posedge clk); #1;
        end
        if (i == maxc) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    vec_t vecs[6];
    int   b0;
    int   nfill;
    int   kind;
    logic [31:0] rp;

    initial begin
        vecs[0] = '{32'h0507F0F0, 1,  0,  5,  7,  5,  7, 'hF0F};
        vecs[1] = '{32'hBC030F00, 4,  4, 60,  3, 63,  3, 'h0F0};
        vecs[2] = '{32'hC0000000, 0,  0,  0,  0,  0,  0, 'h000};
        vecs[3] = '{32'hBF3F1230, 1,  1, 63, 63, 63, 63, 'h123};
        vecs[4] = '{32'h3FFFABCD, 1,  0, 63, 63, 63, 63, 'hABC};
        vecs[5] = '{32'h8005555F, 64, 64, 0,  5, 63,  5, 'h555};

        // Reset state.
        @(negedge clk);
        chk("rst_write_en", 32'(write_en), 0);
        chk("rst_write_x", 32'(write_x), 0);
        chk("rst_write_y", 32'(write_y), 0);
        chk("rst_write_color", 32'(write_color), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            log_q.delete();
            b0 = bcount;
            send_pkt(vecs[v].pkt, v % 2);
            wait_drain(200);
            chk($sformatf("vec%0d_count", v), 32'(log_q.size()), 32'(vecs[v].n));
            chk($sformatf("vec%0d_busy", v), 32'(bcount - b0), 32'(vecs[v].nbusy));
            if (log_q.size() > 0 && vecs[v].n > 0) begin
                chk($sformatf("vec%0d_first", v), {log_q[0].x[15:0], log_q[0].y[15:0]},
                    {vecs[v].fx[15:0], vecs[v].fy[15:0]});
                chk($sformatf("vec%0d_last", v), {log_q[$].x[15:0], log_q[$].y[15:0]},
                    {vecs[v].lx[15:0], vecs[v].ly[15:0]});
                chk($sformatf("vec%0d_color", v), 32'(log_q[0].col), 32'(vecs[v].col));
            end
        end

        // PIXEL latency: write visible in the cycle right after byte 3.
        send_byte(8'h05, 0); send_byte(8'h07, 0); send_byte(8'hF0, 0);
        byte_valid = 1'b1; byte_data = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("pix_latency_we", 32'(write_en), 1);
        chk("pix_latency_busy", 32'(busy), 0);
        chk("pix_latency_color", 32'(write_color), 32'hF0F);
        @(posedge clk); #1;
        wait_drain(50);

        // Resync: two stray bytes, then frame_sync with byte 0.
        log_q.delete();
        send_byte(8'h05, 0); send_byte(8'h07, 0);
        send_byte(8'h02, 1); send_byte(8'h02, 0); send_byte(8'h0A, 0); send_byte(8'h0A, 0);
        wait_drain(50);
        chk("resync_count", 32'(log_q.size()), 1);
        // Bytes 0x0A,0x0A give R=0, G=A, B=0.
        if (log_q.size() > 0) begin
            chk("resync_xy", {log_q[0].x[15:0], log_q[0].y[15:0]}, {16'd2, 16'd2});
            chk("resync_color", 32'(log_q[0].col), 32'h0A0);
        end

        // FILL with a PIXEL queued behind it.
        log_q.delete();
        send_pkt(32'h400000F0, 0);
        idle(20);
        send_pkt(32'h0101FFF0, 0);
        wait_drain(5000);
        chk("fillpend_count", 32'(log_q.size()), 4097);
        if (log_q.size() == 4097) begin
            chk("fillpend_fill_last", {log_q[4095].x[15:0], log_q[4095].y[15:0]}, {16'd63, 16'd63});
            chk("fillpend_fill_color", 32'(log_q[4095].col), 32'h00F);
            chk("fillpend_pixel", {log_q[4096].x[15:0], log_q[4096].y[15:0]}, {16'd1, 16'd1});
            chk("fillpend_pixel_color", 32'(log_q[4096].col), 32'hFFF);
            chk("fillpend_no_gap", 32'(log_q[4096].cyc - log_q[4095].cyc), 1);
        end
        chk("fillpend_overflow", 32'(overflow), 0);

        // Overflow: second queued PIXEL is dropped.
        log_q.delete();
        send_pkt(32'h400000F0, 0);
        idle(10);
        send_pkt(32'h02021110, 0);
        send_pkt(32'h03032220, 0);
        wait_drain(5000);
        chk("ovf_count", 32'(log_q.size()), 4097);
        if (log_q.size() > 0) begin
            chk("ovf_last_xy", {log_q[$].x[15:0], log_q[$].y[15:0]}, {16'd2, 16'd2});
            chk("ovf_last_color", 32'(log_q[$].col), 32'h111);
        end
        chk("ovf_set", 32'(overflow), 1);
        idle(10);
        chk("ovf_sticky", 32'(overflow), 1);

        // Reset in the middle of a FILL.
        log_q.delete();
        send_pkt(32'h4000ABC0, 0);
        for (int i = 0; i < 300 && log_q.size() < 100; i++) idle(1);
        chk("midrst_progress", 32'(log_q.size() >= 100), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_zero", {20'(write_en), write_x, write_y, write_color, busy, overflow}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        log_q.delete();
        idle(30);
        chk("midrst_no_writes", 32'(log_q.size()), 0);
        send_pkt(32'h0A0B1230, 0);
        wait_drain(50);
        chk("midrst_pixel_count", 32'(log_q.size()), 1);
        if (log_q.size() > 0)
            chk("midrst_pixel_xy", {log_q[0].x[15:0], log_q[0].y[15:0]}, {16'd10, 16'd11});

        // Random traffic, checked cycle by cycle against the model.
        nfill = 0;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 99);
            rp = $urandom;
            if (kind < 3 && nfill < 2) begin
                rp[31:30] = 2'b01;
                nfill++;
            end else if (kind < 40) rp[31:30] = 2'b10;
            else if (kind < 92)     rp[31:30] = 2'b00;
            else                    rp[31:30] = 2'b11;
            if (rp[31:30] == 2'b01 && kind >= 3) rp[31:30] = 2'b00;
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) send_byte(8'($urandom), 0);
                send_byte(rp[31:24], 1);
            end else begin
                send_byte(rp[31:24], 0);
            end
            for (int i = 1; i < 4; i++) begin
                idle($urandom_range(0, 2));
                send_byte(rp[31-8*i -: 8], 0);
            end
            idle($urandom_range(0, 5));
        end
        wait_drain(10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
